fix_length_packets2bytes: RTL and testbench
===========================================

FIX_LENGTH_PACKETS2BYTES -- requirements
Module: fix_length_packets2bytes

Interface
REQ-001 SHALL have parameter WORDS_PER_PACKET, default 64, the number of 32-bit words per packet (legal 2..8191).
REQ-002 SHALL have port clock_clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port asi_in0_data  input  32  sink word; bits 31:24 are the first byte in stream order.
REQ-005 SHALL have port asi_in0_valid  input  1  sink word valid.
REQ-006 SHALL have port asi_in0_ready  output  1  sink ready, ready-latency 0.
REQ-007 SHALL have port asi_in0_startofpacket  input  1  first word of packet.
REQ-008 SHALL have port asi_in0_endofpacket  input  1  last word of packet.
REQ-009 SHALL have port asi_in0_empty  input  2  ignored; always 0 for fixed-length packets.
REQ-010 SHALL have port aso_out0_data  output  8  source byte.
REQ-011 SHALL have port aso_out0_valid  output  1  source byte valid.
REQ-012 SHALL have port aso_out0_ready  input  1  downstream ready, ready-latency 0.
REQ-013 SHALL have port coe_frame_err  output  1  one-cycle pulse per framing error.
REQ-014 SHALL have port coe_err_count  output  16  framing errors since reset, saturating.
REQ-015 SHALL have port coe_pkt_count  output  16  completed packets since reset, wraps.

Function
REQ-016 SHALL accept a word on any cycle where asi_in0_valid and asi_in0_ready are both 1.
REQ-017 SHALL hold one word plus a 2-bit byte index; byte order: 31:24, 23:16, 15:8, 7:0.
REQ-018 SHALL drive asi_in0_ready = !hold_valid OR (byte_index==3 AND aso_out0_ready).
REQ-019 SHALL present byte 0 of an accepted word on aso_out0_data with aso_out0_valid=1 in the cycle after acceptance (latency 1).
REQ-020 SHALL advance the byte index only when aso_out0_valid and aso_out0_ready are both 1; data and valid stay stable while stalled.
REQ-021 SHALL sustain 1 byte/cycle; a new word is loaded in the same cycle the last byte transfers, with no bubble.
REQ-022 SHALL deassert aso_out0_valid when the holding register empties and no word is accepted.
REQ-023 SHALL run a framing FSM: IDLE (awaiting SOP) and IN_PKT (word counter 0..WORDS_PER_PACKET-1, 13 bits).
REQ-024 IDLE + accepted SOP word: SHALL forward it, set counter=1, go to IN_PKT; if it also carries EOP, SHALL count error and stay in IDLE.
REQ-025 IN_PKT + accepted word with counter==WORDS_PER_PACKET-1 and EOP: SHALL forward it, increment coe_pkt_count, go to IDLE.
REQ-026 IN_PKT + accepted word with EOP and counter<WORDS_PER_PACKET-1: SHALL forward it, count error, go to IDLE.
REQ-027 IN_PKT + accepted word with counter==WORDS_PER_PACKET-1 and no EOP: SHALL forward it, count error, go to IDLE.
REQ-028 IN_PKT + accepted word with SOP: SHALL count error and restart the packet with that word (forward it, counter=1).
REQ-029 SHALL count at most one error per accepted word, even if several conditions hold at once.
REQ-030 SHALL saturate coe_err_count at 16'hFFFF; coe_pkt_count SHALL wrap from 16'hFFFF to 0.

Reset
REQ-031 SHALL, while reset_reset=1 at a clock edge, clear hold_valid, byte index, and word counter, set FSM to IDLE, and clear both counters.
REQ-032 SHALL reset aso_out0_valid=0, aso_out0_data=0, coe_frame_err=0, and asi_in0_ready=0 during reset; ready goes to 1 the first cycle after reset deasserts.
REQ-033 SHALL discard any partially serialized word or packet on mid-operation reset, with no residual bytes after release.

Configuration
REQ-034 SHALL, with FRAME_CHECK_EN defined, implement REQ-023..REQ-029 and drop (accept, do not forward) non-SOP words received in IDLE, counting each as one error.
REQ-035 SHALL, without FRAME_CHECK_EN, forward every accepted word, omit the FSM, tie coe_frame_err=0 and coe_err_count=0, and increment coe_pkt_count on each accepted EOP word.

Verification
REQ-036 Bench SHALL cover: WORDS_PER_PACKET=4, one packet 0x01020304..0x0D0E0F10 with ready held 1 -> bytes 01..10 on 16 consecutive cycles, pkt_count=1, err_count=0.
REQ-037 Bench SHALL cover: same packet with aso_out0_ready toggling 1,0 -> 16 bytes in order, data stable during stalls, asi_in0_ready low while a word holds bytes 0..2.
REQ-038 Bench SHALL cover: EOP on word 2 of 4 (FRAME_CHECK_EN) -> 8 bytes out, one frame_err pulse, err_count=1, pkt_count=0, FSM back in IDLE.
REQ-039 Bench SHALL cover: non-SOP word 0xAABBCCDD in IDLE (FRAME_CHECK_EN) -> no output bytes, err_count=1; same stimulus without macro -> bytes AA BB CC DD out, err_count=0.
REQ-040 Bench SHALL cover: reset asserted after 6 bytes of a packet -> valid=0 next cycle, counters 0; a following clean packet serializes correctly with pkt_count=1.

Source files
------------

// File: rtl/fix_length_packets2bytes.sv
// Serializes 32-bit Avalon-ST words into bytes, MSB byte first, with 1 byte/cycle throughput.
// Define FRAME_CHECK_EN to enable the fixed-length framing checker and error counters.
module fix_length_packets2bytes #(
   parameter int WORDS_PER_PACKET = 64
) (
   input  logic        clock_clk,
   input  logic        reset_reset,
   input  logic [31:0] asi_in0_data,
   input  logic        asi_in0_valid,
   output logic        asi_in0_ready,
   input  logic        asi_in0_startofpacket,
   input  logic        asi_in0_endofpacket,
   input  logic [1:0]  asi_in0_empty,
   output logic [7:0]  aso_out0_data,
   output logic        aso_out0_valid,
   input  logic        aso_out0_ready,
   output logic        coe_frame_err,
   output logic [15:0] coe_err_count,
   output logic [15:0] coe_pkt_count
);

   logic        hold_valid;
   logic [31:0] hold_data;
   logic [1:0]  byte_index;
   logic        accept;
   logic        out_xfer;
   logic        fwd;
   logic        pkt_done;

   assign asi_in0_ready  = !reset_reset && (!hold_valid || (byte_index == 2'd3 && aso_out0_ready));
   assign accept         = asi_in0_valid && asi_in0_ready;
   assign out_xfer       = hold_valid && aso_out0_ready;
   assign aso_out0_valid = hold_valid;

   always_comb begin
      case (byte_index)
         2'd0:    aso_out0_data = hold_data[31:24];
         2'd1:    aso_out0_data = hold_data[23:16];
         2'd2:    aso_out0_data = hold_data[15:8];
         default: aso_out0_data = hold_data[7:0];
      endcase
   end

   always_ff @(posedge clock_clk) begin
      if (reset_reset) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
         byte_index <= 2'd0;
      end else begin
         if (out_xfer) begin
            if (byte_index == 2'd3) hold_valid <= 1'b0;
            byte_index <= byte_index + 2'd1;
         end
         // NOTE: the later non-blocking load overrides the drain above, giving a bubble-free refill.
         if (accept && fwd) begin
            hold_valid <= 1'b1;
            hold_data  <= asi_in0_data;
            byte_index <= 2'd0;
         end
      end
   end

   always_ff @(posedge clock_clk) begin
      if (reset_reset)   coe_pkt_count <= '0;
      else if (pkt_done) coe_pkt_count <= coe_pkt_count + 16'd1;
   end

`ifdef FRAME_CHECK_EN
   localparam logic [0:0]  IDLE     = 1'b0;
   localparam logic [0:0]  IN_PKT   = 1'b1;
   localparam logic [12:0] LAST_CNT = 13'(WORDS_PER_PACKET - 1);

   logic [0:0]  state, state_nxt;
   logic [12:0] word_cnt, cnt_nxt;
   logic        err_now;
   logic        unused_ok;

   assign unused_ok = ^asi_in0_empty;

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = word_cnt;
      fwd       = 1'b1;
      err_now   = 1'b0;
      pkt_done  = 1'b0;
      if (accept) begin
         if (state == IDLE) begin
            if (asi_in0_startofpacket) begin
               if (asi_in0_endofpacket) begin
                  err_now = 1'b1;
               end else begin
                  state_nxt = IN_PKT;
                  cnt_nxt   = 13'd1;
               end
            end else begin
               fwd     = 1'b0;
               err_now = 1'b1;
            end
         end else if (asi_in0_startofpacket) begin
            err_now = 1'b1;
            if (asi_in0_endofpacket) begin
               state_nxt = IDLE;
               cnt_nxt   = 13'd0;
            end else begin
               cnt_nxt = 13'd1;
            end
         end else if (asi_in0_endofpacket || word_cnt == LAST_CNT) begin
            state_nxt = IDLE;
            cnt_nxt   = 13'd0;
            if (asi_in0_endofpacket && word_cnt == LAST_CNT) pkt_done = 1'b1;
            else                                             err_now  = 1'b1;
         end else begin
            cnt_nxt = word_cnt + 13'd1;
         end
      end
   end

   always_ff @(posedge clock_clk) begin
      if (reset_reset) begin
         state         <= IDLE;
         word_cnt      <= 13'd0;
         coe_frame_err <= 1'b0;
         coe_err_count <= '0;
      end else begin
         state         <= state_nxt;
         word_cnt      <= cnt_nxt;
         coe_frame_err <= err_now;
         if (err_now && coe_err_count != 16'hFFFF) coe_err_count <= coe_err_count + 16'd1;
      end
   end
`else
   logic unused_ok;

   assign unused_ok     = ^{asi_in0_empty, asi_in0_startofpacket};
   assign fwd           = 1'b1;
   assign pkt_done      = accept && asi_in0_endofpacket;
   assign coe_frame_err = 1'b0;
   assign coe_err_count = 16'd0;
`endif

endmodule

// File: tb/tb_fix_length_packets2bytes.sv
// Directed bench for fix_length_packets2bytes with WORDS_PER_PACKET=4; expectations follow FRAME_CHECK_EN.
module tb_fix_length_packets2bytes;

   logic        clk = 1'b0;
   logic        reset_reset;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        in_sop;
   logic        in_eop;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        frame_err;
   logic [15:0] err_count;
   logic [15:0] pkt_count;

   int total = 0;
   int bad   = 0;
   int pulses = 0;

   logic [31:0] w_data[$];
   logic        w_sop[$];
   logic        w_eop[$];
   logic [7:0]  got[$];
   int          got_cyc[$];

   always #5 clk = ~clk;

   fix_length_packets2bytes #(.WORDS_PER_PACKET(4)) dut (
      .clock_clk             (clk),
      .reset_reset           (reset_reset),
      .asi_in0_data          (in_data),
      .asi_in0_valid         (in_valid),
      .asi_in0_ready         (in_ready),
      .asi_in0_startofpacket (in_sop),
      .asi_in0_endofpacket   (in_eop),
      .asi_in0_empty         (2'b00),
      .aso_out0_data         (out_data),
      .aso_out0_valid        (out_valid),
      .aso_out0_ready        (out_ready),
      .coe_frame_err         (frame_err),
      .coe_err_count         (err_count),
      .coe_pkt_count         (pkt_count)
   );

   always @(negedge clk) if (frame_err === 1'b1) pulses++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_reset = 1'b1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; out_ready = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      reset_reset = 1'b0;
   endtask

   // Packet of n words 0x01020304, 0x05060708, ...; EOP on word eop_at.
   task automatic load_packet(input int n, input int eop_at);
      for (int i = 0; i < n; i++) begin
         w_data.push_back({8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)});
         w_sop.push_back(i == 0);
         w_eop.push_back(i == eop_at);
      end
   endtask

   // mode 0: downstream always ready; mode 1: ready toggles 1,0. stop>0 ends after that many bytes.
   task automatic run(input int mode, input int stop);
      int wi = 0;
      int cyc = 0;
      logic stalled = 1'b0;
      logic [7:0] prev = '0;
      got.delete(); got_cyc.delete();
      while (1) begin
         @(negedge clk);
         out_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
         if (wi < w_data.size()) begin
            in_valid = 1'b1; in_data = w_data[wi]; in_sop = w_sop[wi]; in_eop = w_eop[wi];
         end else begin
            in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
         end
         #1;
         if (stalled) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev));
         end
         if (mode == 1 && out_valid && (got.size() % 4) != 3)
            chk("in_ready_low_mid_word", 32'(in_ready), 32'd0);
         stalled = out_valid && !out_ready;
         prev = out_data;
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            got_cyc.push_back(cyc);
         end
         if (in_valid && in_ready) wi++;
         if (stop > 0 && got.size() == stop) break;
         if (wi == w_data.size() && !out_valid && !in_valid) break;
         if (cyc >= 300) begin
            total++; bad++;
            $display("FAIL run_timeout: got %0d bytes after %0d cycles", got.size(), cyc);
            break;
         end
         @(posedge clk);
         cyc++;
      end
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      w_data.delete(); w_sop.delete(); w_eop.delete();
   endtask

   task automatic check_bytes(input string name, input int n);
      chk({name, "_count"}, 32'(got.size()), 32'(n));
      for (int k = 0; k < n && k < got.size(); k++)
         chk({name, "_byte"}, 32'(got[k]), 32'(k + 1));
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_reset = 1'b1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; out_ready = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_pkt_count", 32'(pkt_count), 32'd0);
      reset_reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic test_basic();
      do_reset();
      load_packet(4, 3);
      run(0, 0);
      check_bytes("basic", 16);
      if (got_cyc.size() == 16) begin
         chk("basic_latency", 32'(got_cyc[0]), 32'd1);
         chk("basic_no_bubble", 32'(got_cyc[15] - got_cyc[0]), 32'd15);
      end
      chk("basic_pkt_count", 32'(pkt_count), 32'd1);
      chk("basic_err_count", 32'(err_count), 32'd0);
   endtask

   task automatic test_stall();
      do_reset();
      load_packet(4, 3);
      run(1, 0);
      check_bytes("stall", 16);
      chk("stall_pkt_count", 32'(pkt_count), 32'd1);
      chk("stall_err_count", 32'(err_count), 32'd0);
   endtask

   task automatic test_short_packet();
      int p0;
      do_reset();
      p0 = pulses;
      load_packet(2, 1);
      run(0, 0);
      check_bytes("short", 8);
`ifdef FRAME_CHECK_EN
      chk("short_err_pulses", 32'(pulses - p0), 32'd1);
      chk("short_err_count", 32'(err_count), 32'd1);
      chk("short_pkt_count", 32'(pkt_count), 32'd0);
`else
      chk("short_err_pulses", 32'(pulses - p0), 32'd0);
      chk("short_err_count", 32'(err_count), 32'd0);
      chk("short_pkt_count", 32'(pkt_count), 32'd1);
`endif
      // A clean packet afterwards completes only if the framer returned to IDLE.
      load_packet(4, 3);
      run(0, 0);
      check_bytes("after_short", 16);
`ifdef FRAME_CHECK_EN
      chk("after_short_pkt_count", 32'(pkt_count), 32'd1);
      chk("after_short_err_count", 32'(err_count), 32'd1);
`else
      chk("after_short_pkt_count", 32'(pkt_count), 32'd2);
      chk("after_short_err_count", 32'(err_count), 32'd0);
`endif
   endtask

   task automatic test_idle_nonsop();
      logic [7:0] exp_b[4];
      exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
      do_reset();
      w_data.push_back(32'hAABBCCDD); w_sop.push_back(1'b0); w_eop.push_back(1'b0);
      run(0, 0);
`ifdef FRAME_CHECK_EN
      chk("nonsop_bytes", 32'(got.size()), 32'd0);
      chk("nonsop_err_count", 32'(err_count), 32'd1);
`else
      chk("nonsop_bytes", 32'(got.size()), 32'd4);
      for (int k = 0; k < 4 && k < got.size(); k++)
         chk("nonsop_byte", 32'(got[k]), 32'(exp_b[k]));
      chk("nonsop_err_count", 32'(err_count), 32'd0);
`endif
      chk("nonsop_pkt_count", 32'(pkt_count), 32'd0);
   endtask

   task automatic test_mid_reset();
      do_reset();
      load_packet(4, 3);
      run(0, 6);
      chk("mid_bytes_before_reset", 32'(got.size()), 32'd6);
      reset_reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
      chk("mid_rst_err_count", 32'(err_count), 32'd0);
      reset_reset = 1'b0;
      load_packet(4, 3);
      run(0, 0);
      check_bytes("mid_clean", 16);
      chk("mid_clean_pkt_count", 32'(pkt_count), 32'd1);
      chk("mid_clean_err_count", 32'(err_count), 32'd0);
   endtask

   initial begin
      reset_reset = 1'b1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; out_ready = 1'b1;
      test_reset();
      test_basic();
      test_stall();
      test_short_packet();
      test_idle_nonsop();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
